// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing a multicycle CPU datapath with one shared memory port
// Ports:
//   clk, rst (async, active-low)
//   Cond/Op/Funct/Rd  instruction fields from the instruction register
//   ALUFlags          {N,Z,C,V} produced by the ALU this cycle
//   mem_ready         memory completes the current request this cycle
//   mem_req .. ALUControl  datapath strobes and selects
//   ImmSrc, RegSrc    decode passthroughs
//   Flags             stored {N,Z,C,V}; state = current FSM state (debug)
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [3:0]         Flags,
    output logic [STATE_W-1:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t st, nx;
    logic [3:0] cmd;
    logic is_add, is_sub, is_and, is_orr, is_cmp, legal, arith, dp_write, cond_ex;
    logic [1:0] alu_op;
    logic n, z, c, v;

    assign cmd      = Funct[4:1];
    assign is_add   = cmd == 4'b0100;
    assign is_sub   = cmd == 4'b0010;
    assign is_and   = cmd == 4'b0000;
    assign is_orr   = cmd == 4'b1100;
    assign is_cmp   = cmd == 4'b1010;
    assign legal    = is_add | is_sub | is_and | is_orr | is_cmp;
    assign arith    = is_add | is_sub | is_cmp;
    assign dp_write = legal & ~is_cmp;
    // CMP reuses SUB; illegal commands fall back to ADD
    assign alu_op   = (is_sub | is_cmp) ? 2'b01 : is_and ? 2'b10 : is_orr ? 2'b11 : 2'b00;

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign state  = STATE_W'(st);
    assign {n, z, c, v} = Flags;

    // condition check uses stored flags only, so a flag-setting instruction
    // affects the next instruction's DECODE, never its own
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = n == v;
            4'b1011: cond_ex = n != v;
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= FETCH;
            Flags <= 4'b0000;
        end else begin
            st <= nx;
            if ((st == EXECR || st == EXECI) && Funct[0] && legal) begin
                Flags[3:2] <= ALUFlags[3:2];
                if (arith)
                    Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        nx         = st;
        mem_req    = 1'b0;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        // while reset is held every strobe stays low even though st reads FETCH
        if (rst) begin
            case (st)
                FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    nx        = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    nx        = !cond_ex ? FETCH :
                                Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                                Op == 2'b01 ? MEMADR :
                                Op == 2'b10 ? BRANCH : FETCH;
                end
                EXECR: begin
                    ALUControl = alu_op;
                    nx         = ALUWB;
                end
                EXECI: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_op;
                    nx         = ALUWB;
                end
                ALUWB: begin
                    RegWrite = dp_write;
                    PCWrite  = dp_write && Rd == 4'd15;
                    nx       = FETCH;
                end
                MEMADR: begin
                    ALUSrcB = 2'b01;
                    nx      = Funct[0] ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    nx      = mem_ready ? MEMWB : MEMRD;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = mem_ready;
                    nx       = mem_ready ? FETCH : MEMWR;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    PCWrite   = Rd == 4'd15;
                    nx        = FETCH;
                end
                BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    nx        = FETCH;
                end
                default: nx = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-cycle trace check of the multicycle controller against an instruction-level model
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Cond, Rd, ALUFlags, Flags, state;
    logic [1:0] Op, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [5:0] Funct;
    logic       mem_ready, mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .mem_ready(mem_ready), .mem_req(mem_req),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .state(state)
    );

    always #5 clk = ~clk;

    // one clock cycle: inputs applied, outputs expected
    typedef struct packed {
        logic       mr;
        logic [3:0] af;
        logic [3:0] st;
        logic [3:0] fl;
        logic       req, pcw, adr, mw, irw, rw;
        logic [1:0] rs;
        logic       sa;
        logic [1:0] sb, ac;
    } vec_t;

    vec_t       q[$];
    logic [3:0] mflags;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (c)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && fn == fv;
            4'hD: return fz || fn != fv;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t blank(input logic [3:0] st, input logic mr);
        vec_t r = '0;
        r.st = st;
        r.mr = mr;
        r.af = 4'($urandom);
        r.fl = mflags;
        return r;
    endfunction

    // expected cycle-by-cycle trace of one instruction, from fetch to its last state
    task automatic build(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] d,
                         input int fwt, input int mwt, input logic [3:0] eaf);
        vec_t r;
        logic [3:0] cmd = f[4:1];
        bit legal = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        bit arith = cmd inside {4'b0100, 4'b0010, 4'b1010};
        bit wr = legal && cmd != 4'b1010;
        logic [1:0] alu = (cmd == 4'b0010 || cmd == 4'b1010) ? 2'd1 : cmd == 4'b0000 ? 2'd2 :
                          cmd == 4'b1100 ? 2'd3 : 2'd0;
        for (int i = 0; i <= fwt; i++) begin
            r = blank(4'd0, i == fwt);
            r.req = 1; r.sa = 1; r.sb = 2'd2; r.rs = 2'd2;
            r.pcw = i == fwt; r.irw = i == fwt;
            q.push_back(r);
        end
        r = blank(4'd1, 1'($urandom));
        r.sa = 1; r.sb = 2'd2; r.rs = 2'd2;
        q.push_back(r);
        if (!cond_ok(c, mflags) || o == 2'd3) return;
        if (o == 2'd0) begin
            r = blank(f[5] ? 4'd7 : 4'd6, 1'($urandom));
            r.sb = f[5] ? 2'd1 : 2'd0; r.ac = alu; r.af = eaf;
            q.push_back(r);
            if (f[0] && legal) begin
                mflags[3:2] = eaf[3:2];
                if (arith) mflags[1:0] = eaf[1:0];
            end
            r = blank(4'd8, 1'($urandom));
            r.rw = wr; r.pcw = wr && d == 4'd15;
            q.push_back(r);
        end else if (o == 2'd1) begin
            r = blank(4'd2, 1'($urandom));
            r.sb = 2'd1;
            q.push_back(r);
            for (int i = 0; i <= mwt; i++) begin
                r = blank(f[0] ? 4'd3 : 4'd5, i == mwt);
                r.req = 1; r.adr = 1; r.mw = !f[0] && i == mwt;
                q.push_back(r);
            end
            if (f[0]) begin
                r = blank(4'd4, 1'($urandom));
                r.rs = 2'd1; r.rw = 1; r.pcw = d == 4'd15;
                q.push_back(r);
            end
        end else begin
            r = blank(4'd9, 1'($urandom));
            r.sb = 2'd1; r.rs = 2'd2; r.pcw = 1;
            q.push_back(r);
        end
    endtask

    task automatic run(input string name, input logic [3:0] c, input logic [1:0] o,
                       input logic [5:0] f, input logic [3:0] d);
        vec_t r;
        int cyc = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            Cond = c; Op = o; Funct = f; Rd = d;
            mem_ready = r.mr; ALUFlags = r.af;
            #1;
            chk(name, cyc,
                {7'd0, state, Flags, mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc},
                {7'd0, r.st, r.fl, r.req, r.pcw, r.adr, r.mw, r.irw, r.rw,
                 r.rs, r.sa, r.sb, r.ac, o, o == 2'b01, o == 2'b10});
            cyc++;
        end
    endtask

    task automatic instr(input string name, input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] d, input int fwt, input int mwt, input logic [3:0] eaf);
        build(c, o, f, d, fwt, mwt, eaf);
        run(name, c, o, f, d);
    endtask

    vec_t add_tbl[5];

    initial begin
        // ADD R1,R2,#5: FETCH (ready), DECODE, EXECI, ALUWB, back to FETCH (not ready)
        add_tbl[0] = '{1'b1, 4'h0, 4'd0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 2'd2, 2'd0};
        add_tbl[1] = '{1'b0, 4'h0, 4'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd0};
        add_tbl[2] = '{1'b1, 4'hF, 4'd7, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0};
        add_tbl[3] = '{1'b1, 4'h0, 4'd8, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0};
        add_tbl[4] = '{1'b0, 4'h0, 4'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd0};

        rst = 1'b0; Cond = 4'hE; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'h0; mem_ready = 1'b1;
        mflags = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset", 0, {12'd0, state, Flags, mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                         ResultSrc, ALUSrcA, ALUSrcB, ALUControl}, 32'd0);
        rst = 1'b1;
        mem_ready = 1'b0;

        foreach (add_tbl[i]) q.push_back(add_tbl[i]);
        run("add_imm", 4'hE, 2'd0, 6'b101000, 4'd1);

        instr("fetch_wait", 4'hE, 2'd0, 6'b101000, 4'd1, 3, 0, 4'h0);
        instr("subs_z", 4'hE, 2'd0, 6'b000101, 4'd3, 0, 0, 4'b0110);
        instr("beq_taken", 4'h0, 2'd2, 6'b100000, 4'd0, 1, 0, 4'h0);
        instr("subs_n", 4'hE, 2'd0, 6'b000101, 4'd3, 0, 0, 4'b1000);
        instr("beq_skip", 4'h0, 2'd2, 6'b100000, 4'd0, 0, 0, 4'h0);
        instr("ldr_pc", 4'hE, 2'd1, 6'b011001, 4'd15, 0, 2, 4'h0);
        instr("subs_z1", 4'hE, 2'd0, 6'b000101, 4'd3, 0, 0, 4'b0100);
        instr("strne_skip", 4'h1, 2'd1, 6'b011000, 4'd2, 0, 0, 4'h0);
        instr("subs_z0", 4'hE, 2'd0, 6'b000101, 4'd3, 0, 0, 4'b0000);
        instr("strne_do", 4'h1, 2'd1, 6'b011000, 4'd2, 0, 1, 4'h0);
        instr("cmp_pc", 4'hE, 2'd0, 6'b010101, 4'd15, 0, 0, 4'b1011);
        instr("ands_pc", 4'hE, 2'd0, 6'b000001, 4'd15, 0, 0, 4'b0111);
        instr("illegal", 4'hE, 2'd0, 6'b011111, 4'd15, 0, 0, 4'b1111);
        instr("never", 4'hF, 2'd2, 6'b000000, 4'd0, 0, 0, 4'h0);

        for (int k = 0; k < 300; k++) begin
            logic [3:0] rc, rd, eaf;
            logic [1:0] ro;
            logic [5:0] rf;
            rc  = ($urandom % 3 == 0) ? 4'hE : 4'($urandom);
            ro  = 2'($urandom);
            rf  = 6'($urandom);
            rd  = ($urandom % 4 == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            eaf = 4'($urandom);
            instr("random", rc, ro, rf, rd, $urandom_range(0, 2), $urandom_range(0, 2), eaf);
        end

        // make flags nonzero so the reset check below sees them cleared
        instr("subs_pre", 4'hE, 2'd0, 6'b000101, 4'd3, 0, 0, 4'b1010);
        @(negedge clk);
        Cond = 4'hE; Op = 2'd1; Funct = 6'b000001; Rd = 4'd2; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("memrd_wait", 0, {28'd0, state}, 32'd3);
        rst = 1'b0;
        #1;
        chk("mid_reset", 0, {21'd0, state, Flags, mem_req, MemWrite, RegWrite}, 32'd0);
        @(negedge clk);
        #1;
        chk("reset_hold", 0, {21'd0, state, Flags, mem_req, PCWrite, IRWrite}, 32'd0);
        rst = 1'b1;
        #1;
        chk("post_reset", 0, {23'd0, state, Flags, mem_req}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the CPU datapath in multicycle mode. One shared memory port serves both instruction fetch and data access, and the ALU is reused for PC increment and address generation.
- Decodes Cond/Op/Funct/Rd from the instruction register and keeps the NZCV flags register.
- Drives all datapath select and write-enable strobes.
- Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the debug state output.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (for memory ops, [0]=L).
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  store strobe.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=const 4.
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.
- ImmSrc  out  2  Op passed through: 00 data-processing imm8, 01 memory imm12, 10 branch imm24.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- Flags  out  4  stored {N,Z,C,V}.
- state  out  STATE_W  current FSM state (debug).

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 are illegal and go to FETCH next cycle with all strobes 0.
- Reset (rst low, asynchronous): state=FETCH, Flags=0000. Every strobe is 0 while rst is low. Decoding resumes on the first rising edge after rst deasserts, including when reset hits mid-instruction.
- Default strobes in every state: all 0, selects 0, except as listed below.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; the FSM moves to DECODE on that cycle.
  - Otherwise the FSM holds in FETCH.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 = PC+8 read).
  - If CondEx=0, go to FETCH.
  - Else Op=00: go to EXECI if I=1, else EXECR.
  - Else Op=01: go to MEMADR.
  - Else Op=10: go to BRANCH.
  - Op=11 goes to FETCH (NOP).
- EXECR / EXECI:
  - ALUSrcA=0; ALUSrcB=00 in EXECR, 01 in EXECI; ALUControl from cmd.
  - Next state ALUWB.
  - Flag update on the rising edge ending this state:
    - if S=1 and cmd is legal, N,Z <= ALUFlags[3:2];
    - C,V <= ALUFlags[1:0] only for ADD, SUB or CMP.
- ALUWB:
  - ResultSrc=00; RegWrite=1 unless cmd=CMP or cmd is illegal.
  - If RegWrite=1 and Rd=15, PCWrite=1.
  - Next state FETCH.
- MEMADR:
  - ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
  - Go to MEMRD if L=1, else MEMWR.
- MEMRD:
  - mem_req=1, AdrSrc=1.
  - Hold until mem_ready, then go to MEMWB.
- MEMWR:
  - mem_req=1, AdrSrc=1.
  - MemWrite=1 only in the cycle mem_ready=1, then go to FETCH.
- MEMWB:
  - ResultSrc=01, RegWrite=1; PCWrite=1 if Rd=15.
  - Next state FETCH.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next state FETCH.
- cmd decode:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no write).
  - Any other cmd is illegal: ALUControl=ADD, no RegWrite, no flag update.
- CondEx: combinational from the stored Flags (never from ALUFlags).
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 gives 0.
- Flag write timing: flags written by instruction k are visible in instruction k+1's DECODE.
- mem_ready is ignored in states with mem_req=0.

Test Plan:
- Reset mid-operation: drive rst low while in MEMRD with mem_ready=0 -> state=0 immediately; mem_req=0, MemWrite=0, RegWrite=0, Flags=0000. After release, FETCH asserts mem_req=1.
- ADD R1,R2,#5 (Cond=1110, Op=00, Funct=101000, Rd=1) with mem_ready=1 -> state sequence 0,1,7,8,0.
  - IRWrite=PCWrite=1 in the FETCH cycle only.
  - RegWrite=1 only in ALUWB.
  - ALUSrcB=01 in EXECI.
- Fetch wait: mem_ready low for 3 cycles, then high -> FETCH lasts 4 cycles; mem_req=1 throughout; IRWrite and PCWrite pulse once, in the 4th cycle.
- SUBS (Funct=000101) with ALUFlags=0110 -> Flags=0110 after EXECR.
  - Following BEQ (Cond=0000, Op=10) -> states 1,9 with PCWrite=1 in BRANCH.
  - Repeat with ALUFlags=1000 -> BEQ goes DECODE to FETCH with no PCWrite outside FETCH.
- LDR PC (Op=01, L=1, Rd=15) with mem_ready delayed 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MEMWB has RegWrite=1 and PCWrite=1.
- STR with Cond=0001 (NE) while Z=1 -> states 0,1,0; MemWrite never 1; mem_req low in DECODE.
  - Same STR with Z=0 -> states 0,1,2,5,0; MemWrite=1 for exactly one cycle.
